ethpipe_rx_slot_ctrl: RTL and testbench
=======================================

ETHPIPE_RX_SLOT_CTRL -- requirements
Module: ethpipe_rx_slot_ctrl

Interface
REQ-001 Parameter SLOT_BITS, default 2, log2 of RX slot count (SLOTS = 2**SLOT_BITS, legal 1..4).
REQ-002 Parameter HOLD, default 4, minimum pci_clk cycles rx_empty stays low after each accepted frame (legal 2..15).
REQ-003 pci_clk  in  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  in  1  synchronous reset, active-high.
REQ-005 rx_complete  in  1  one-cycle pulse, already in pci_clk domain: receiver finished writing slot rx_wr_slot.
REQ-006 rx_frame_len  in  12, rx_timestamp  in  64  descriptor of the frame; stable when rx_complete is high.
REQ-007 rx_empty  out  1  high = rx_wr_slot is free, receiver may fill it.
REQ-008 rx_wr_slot  out  SLOT_BITS  slot index the receiver writes next.
REQ-009 host_valid  out  1, host_rd_slot  out  SLOT_BITS, host_frame_len  out  12, host_timestamp  out  64: oldest filled slot and its descriptor.
REQ-010 host_release  in  1  one-cycle pulse: host finished with host_rd_slot.
REQ-011 irq_enable  in  1, irq_threshold  in  SLOT_BITS+1, irq_timeout  in  16: interrupt coalescing controls.
REQ-012 irq  out  1  level interrupt; irq_ack  in  1  one-cycle pulse clearing it.
REQ-013 fill_count  out  SLOT_BITS+1  filled slots; err_count  out  16  protocol violations, saturating.

Function
REQ-014 Slots SHALL form a circular queue: wr_ptr, rd_ptr (SLOT_BITS, wrap modulo SLOTS), count (0..SLOTS); rx_wr_slot = wr_ptr, host_rd_slot = rd_ptr, fill_count = count.
REQ-015 Accepted rx_complete (rx_empty high) SHALL store len/timestamp at wr_ptr, wr_ptr+1, count+1, all visible next cycle.
REQ-016 rx_complete while rx_empty low SHALL be dropped (no pointer/count/descriptor change) and err_count +1.
REQ-017 host_release with count>0 SHALL advance rd_ptr, count-1 next cycle; with count==0 SHALL be ignored and err_count +1.
REQ-018 Simultaneous accepted rx_complete and valid host_release SHALL advance both pointers, count unchanged.
REQ-019 host_valid = (count!=0); host_frame_len/host_timestamp SHALL be registered copies of descriptor at rd_ptr, updated one cycle after rd_ptr/store change; 0 when count==0.
REQ-020 rx_empty FSM states R_READY (rx_empty=1), R_HOLD (0), R_FULL (0).
REQ-021 R_READY: accepted rx_complete -> R_HOLD, hold counter loaded with HOLD-1.
REQ-022 R_HOLD: decrement each cycle; at 0 -> R_READY if count<SLOTS else R_FULL.
REQ-023 R_FULL: -> R_READY the cycle after count<SLOTS.
REQ-024 rx_empty SHALL therefore produce a fresh low-to-high edge per accepted frame, as required by the receiver's edge synchroniser.
REQ-025 irq FSM states I_IDLE, I_WAIT, I_ASSERT; irq=1 only in I_ASSERT.
REQ-026 I_IDLE -> I_WAIT when irq_enable and count>0; 16-bit timer cleared.
REQ-027 I_WAIT: timer +1 per cycle (saturating); -> I_ASSERT when count >= max(irq_threshold,1) or (irq_timeout!=0 and timer==irq_timeout); irq_enable low -> I_IDLE.
REQ-028 I_ASSERT: hold until irq_ack, then -> I_IDLE; irq_ack in other states ignored.
REQ-029 irq_enable low SHALL never deassert irq already in I_ASSERT.
REQ-030 All counters/pointers SHALL wrap or saturate exactly as stated; no X on outputs after reset.

Reset
REQ-031 sys_rst SHALL, next edge, set pointers/count/err_count/timer 0, descriptors 0, R_READY, I_IDLE: rx_empty=1, rx_wr_slot=0, host_valid=0, irq=0, fill_count=0.
REQ-032 Reset mid-frame or mid-hold SHALL discard all slot contents; stimuli during reset ignored.

Verification
REQ-033 Reset, then rx_complete len=64 ts=0x100 -> next cycle rx_wr_slot=1, host_valid=1, host_rd_slot=0, fill_count=1; rx_empty low exactly 4 cycles (HOLD=4), then high.
REQ-034 Four accepted frames, no release -> rx_empty stays low (R_FULL); rx_complete then -> err_count=1, fill_count=4; one host_release -> rx_empty high one cycle after count=3.
REQ-035 Same-cycle rx_complete and host_release with count=2 -> count stays 2, both pointers +1; pointer 3 wraps to 0.
REQ-036 irq_enable=1, threshold=3, timeout=0: two frames -> irq 0; third -> irq 1; irq_ack -> irq 0, re-enters I_WAIT, timer restarts.
REQ-037 threshold=4, timeout=10, one frame -> irq rises exactly 10 cycles after I_WAIT entry; host_release with count=0 -> err_count +1, no pointer change.

Source files
------------

// File: rtl/ethpipe_rx_slot_ctrl.sv
// RX slot controller: circular queue of receive slots between the GMII
// receiver and the host. It tracks descriptors (length, timestamp) per slot,
// paces rx_empty so each accepted frame yields a fresh low-to-high edge,
// counts protocol violations and coalesces host interrupts.
module ethpipe_rx_slot_ctrl #(
  parameter int SLOT_BITS = 2,
  parameter int HOLD      = 4
) (
  input  logic                 pci_clk,
  input  logic                 sys_rst,
  input  logic                 rx_complete,
  input  logic [11:0]          rx_frame_len,
  input  logic [63:0]          rx_timestamp,
  output logic                 rx_empty,
  output logic [SLOT_BITS-1:0] rx_wr_slot,
  output logic                 host_valid,
  output logic [SLOT_BITS-1:0] host_rd_slot,
  output logic [11:0]          host_frame_len,
  output logic [63:0]          host_timestamp,
  input  logic                 host_release,
  input  logic                 irq_enable,
  input  logic [SLOT_BITS:0]   irq_threshold,
  input  logic [15:0]          irq_timeout,
  output logic                 irq,
  input  logic                 irq_ack,
  output logic [SLOT_BITS:0]   fill_count,
  output logic [15:0]          err_count
);

  localparam int SLOTS = 1 << SLOT_BITS;
  localparam logic [SLOT_BITS:0] SLOTS_C = (SLOT_BITS+1)'(SLOTS);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  typedef enum logic [1:0] {R_READY, R_HOLD, R_FULL} r_state_t;
  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_ASSERT} i_state_t;

  r_state_t r_state, r_next;
  i_state_t i_state, i_next;
  logic [3:0]  hold_cnt, hold_next;
  logic [15:0] timer, timer_next, timer_inc;

  logic [SLOT_BITS-1:0] wr_ptr, rd_ptr;
  logic [SLOT_BITS:0]   count, thr_eff;
  logic [11:0] len_mem [SLOTS];
  logic [63:0] ts_mem  [SLOTS];
  logic [11:0] host_len_p1;
  logic [63:0] host_ts_p1;

  logic accept, drop, rel_ok, rel_bad;

  // Saturating add used by the error counter (two violations can coincide).
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Saturating increment for the coalescing timer.
  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  assign rx_empty = (r_state == R_READY);
  assign accept   = rx_complete & rx_empty;
  assign drop     = rx_complete & ~rx_empty;
  assign rel_ok   = host_release & (count != '0);
  assign rel_bad  = host_release & (count == '0);
  assign thr_eff  = (irq_threshold == '0) ? (SLOT_BITS+1)'(1) : irq_threshold;
  assign timer_inc = sat_inc16(timer);

  assign rx_wr_slot     = wr_ptr;
  assign host_rd_slot   = rd_ptr;
  assign fill_count     = count;
  assign host_valid     = (count != '0);
  assign host_frame_len = host_len_p1;
  assign host_timestamp = host_ts_p1;
  assign irq            = (i_state == I_ASSERT);

  // Queue pointers, occupancy, descriptor store and error counter.
  always_ff @(posedge pci_clk) begin
    if (sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        len_mem[i] <= '0;
        ts_mem[i]  <= '0;
      end
    end else begin
      if (accept) begin
        len_mem[wr_ptr] <= rx_frame_len;
        ts_mem[wr_ptr]  <= rx_timestamp;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (rel_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, rel_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      err_count <= sat_add16(err_count, {1'b0, drop} + {1'b0, rel_bad});
    end
  end

  // Stage p1: registered copy of the descriptor at the read pointer.
  always_ff @(posedge pci_clk) begin
    if (sys_rst) begin
      host_len_p1 <= '0;
      host_ts_p1  <= '0;
    end else begin
      host_len_p1 <= (count != '0) ? len_mem[rd_ptr] : '0;
      host_ts_p1  <= (count != '0) ? ts_mem[rd_ptr]  : '0;
    end
  end

  // State registers for the rx_empty pacing FSM and the interrupt FSM.
  always_ff @(posedge pci_clk) begin
    if (sys_rst) begin
      r_state  <= R_READY;
      hold_cnt <= '0;
      i_state  <= I_IDLE;
      timer    <= '0;
    end else begin
      r_state  <= r_next;
      hold_cnt <= hold_next;
      i_state  <= i_next;
      timer    <= timer_next;
    end
  end

  // rx_empty pacing: hold low HOLD cycles per frame, then wait for a free slot.
  always_comb begin
    r_next    = r_state;
    hold_next = hold_cnt;
    case (r_state)
      R_READY: if (accept) begin
        r_next    = R_HOLD;
        hold_next = HOLD_LOAD;
      end
      R_HOLD: begin
        if (hold_cnt == '0) r_next = (count < SLOTS_C) ? R_READY : R_FULL;
        else                hold_next = hold_cnt - 4'd1;
      end
      R_FULL:  if (count < SLOTS_C) r_next = R_READY;
      default: r_next = R_READY;
    endcase
  end

  // Interrupt coalescing; timer_inc counts WAIT cycles including the current one.
  always_comb begin
    i_next     = i_state;
    timer_next = timer;
    case (i_state)
      I_IDLE: if (irq_enable && (count != '0)) begin
        i_next     = I_WAIT;
        timer_next = '0;
      end
      I_WAIT: begin
        timer_next = timer_inc;
        if (!irq_enable) i_next = I_IDLE;
        else if ((count >= thr_eff) ||
                 ((irq_timeout != '0) && (timer_inc == irq_timeout)))
          i_next = I_ASSERT;
      end
      I_ASSERT: if (irq_ack) i_next = I_IDLE;
      default:  i_next = I_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ethpipe_rx_slot_ctrl.sv
// Testbench for ethpipe_rx_slot_ctrl (SLOT_BITS=2, HOLD=4). Accepted frame
// descriptors go into a scoreboard queue and are compared against the host
// descriptor outputs when the bench releases each slot.
module tb_ethpipe_rx_slot_ctrl;

  localparam int SB = 2;
  localparam int HOLD_P = 4;

  typedef struct {
    logic [11:0] len;
    logic [63:0] ts;
  } desc_t;

  logic          pci_clk = 1'b0;
  logic          sys_rst;
  logic          rx_complete;
  logic [11:0]   rx_frame_len;
  logic [63:0]   rx_timestamp;
  logic          rx_empty;
  logic [SB-1:0] rx_wr_slot;
  logic          host_valid;
  logic [SB-1:0] host_rd_slot;
  logic [11:0]   host_frame_len;
  logic [63:0]   host_timestamp;
  logic          host_release;
  logic          irq_enable;
  logic [SB:0]   irq_threshold;
  logic [15:0]   irq_timeout;
  logic          irq;
  logic          irq_ack;
  logic [SB:0]   fill_count;
  logic [15:0]   err_count;

  int errors = 0;
  int checks = 0;
  desc_t sb[$];

  ethpipe_rx_slot_ctrl #(.SLOT_BITS(SB), .HOLD(HOLD_P)) dut (
    .pci_clk(pci_clk), .sys_rst(sys_rst),
    .rx_complete(rx_complete), .rx_frame_len(rx_frame_len), .rx_timestamp(rx_timestamp),
    .rx_empty(rx_empty), .rx_wr_slot(rx_wr_slot),
    .host_valid(host_valid), .host_rd_slot(host_rd_slot),
    .host_frame_len(host_frame_len), .host_timestamp(host_timestamp),
    .host_release(host_release), .irq_enable(irq_enable),
    .irq_threshold(irq_threshold), .irq_timeout(irq_timeout),
    .irq(irq), .irq_ack(irq_ack), .fill_count(fill_count), .err_count(err_count)
  );

  always #5 pci_clk = ~pci_clk;

  initial begin
    #100000;
    $display("FAIL watchdog sim_time got=expired want=finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge pci_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_rst = 1'b1; rx_complete = 1'b0; rx_frame_len = '0; rx_timestamp = '0;
    host_release = 1'b0; irq_enable = 1'b0; irq_threshold = '0;
    irq_timeout = '0; irq_ack = 1'b0;
    tick; tick;
    sys_rst = 1'b0;
    sb.delete();
  endtask

  // Drive one frame the bench expects the DUT to accept and record it.
  task automatic send_frame(input logic [11:0] len, input logic [63:0] ts);
    desc_t d;
    d.len = len; d.ts = ts;
    rx_frame_len = len; rx_timestamp = ts; rx_complete = 1'b1;
    sb.push_back(d);
    tick;
    rx_complete = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (rx_empty !== 1'b1 && n < 40) begin tick; n++; end
    checks++;
    if (rx_empty !== 1'b1) begin
      errors++; $display("FAIL %s_wait_ready got=timeout want=rx_empty_high", tag);
    end
  endtask

  // Let the descriptor settle, compare it with the oldest expected frame, release it.
  task automatic release_front(input string tag);
    desc_t d;
    tick;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s_sb_empty got=empty want=entry", tag);
    end else begin
      d = sb.pop_front();
      if (host_valid !== 1'b1 || host_frame_len !== d.len || host_timestamp !== d.ts) begin
        errors++;
        $display("FAIL %s_desc got=v%0d len=%h ts=%h want=v1 len=%h ts=%h",
                 tag, host_valid, host_frame_len, host_timestamp, d.len, d.ts);
      end
    end
    host_release = 1'b1;
    tick;
    host_release = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty got=%0d want=1", rx_empty); end
    checks++; if (rx_wr_slot !== 2'd0) begin errors++; $display("FAIL reset_wr_slot got=%0d want=0", rx_wr_slot); end
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL reset_host_valid got=%0d want=0", host_valid); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0d want=0", irq); end
    checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d want=0", fill_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got=%0d want=0", err_count); end
    checks++; if (host_frame_len !== 12'd0 || host_timestamp !== 64'd0) begin
      errors++; $display("FAIL reset_desc got=%h/%h want=0/0", host_frame_len, host_timestamp); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    send_frame(12'd100, 64'hDEAD);
    tick;
    sys_rst = 1'b1; rx_complete = 1'b1; host_release = 1'b1;
    tick;
    sys_rst = 1'b0; rx_complete = 1'b0; host_release = 1'b0;
    sb.delete();
    checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL midrst_fill got=%0d want=0", fill_count); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL midrst_rx_empty got=%0d want=1", rx_empty); end
    checks++; if (rx_wr_slot !== 2'd0) begin errors++; $display("FAIL midrst_wr_slot got=%0d want=0", rx_wr_slot); end
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL midrst_host_valid got=%0d want=0", host_valid); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL midrst_err got=%0d want=0", err_count); end
    checks++; if (host_frame_len !== 12'd0) begin errors++; $display("FAIL midrst_len got=%h want=0", host_frame_len); end
  endtask

  task automatic test_single;
    int lowc = 0;
    do_reset;
    send_frame(12'd64, 64'h100);
    checks++; if (rx_wr_slot !== 2'd1) begin errors++; $display("FAIL single_wr_slot got=%0d want=1", rx_wr_slot); end
    checks++; if (host_valid !== 1'b1) begin errors++; $display("FAIL single_host_valid got=%0d want=1", host_valid); end
    checks++; if (host_rd_slot !== 2'd0) begin errors++; $display("FAIL single_rd_slot got=%0d want=0", host_rd_slot); end
    checks++; if (fill_count !== 3'd1) begin errors++; $display("FAIL single_fill got=%0d want=1", fill_count); end
    while (rx_empty === 1'b0 && lowc < 20) begin lowc++; tick; end
    checks++; if (lowc != HOLD_P || rx_empty !== 1'b1) begin
      errors++; $display("FAIL single_hold_len got=%0d want=%0d", lowc, HOLD_P); end
    release_front("single");
    tick;
    checks++; if (host_valid !== 1'b0 || host_frame_len !== 12'd0) begin
      errors++; $display("FAIL single_drained got=v%0d len=%h want=v0 len=0", host_valid, host_frame_len); end
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      send_frame(12'(200 + i), 64'(64'h1000 + i));
      if (i < 3) wait_ready("full_fill");
    end
    repeat (8) tick;
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL full_rx_empty got=%0d want=0", rx_empty); end
    checks++; if (fill_count !== 3'd4) begin errors++; $display("FAIL full_fill got=%0d want=4", fill_count); end
    rx_frame_len = 12'hABC; rx_timestamp = 64'hBAD; rx_complete = 1'b1;
    tick;
    rx_complete = 1'b0;
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL full_drop_err got=%0d want=1", err_count); end
    checks++; if (fill_count !== 3'd4 || rx_wr_slot !== 2'd0) begin
      errors++; $display("FAIL full_drop_state got=fill%0d wr%0d want=fill4 wr0", fill_count, rx_wr_slot); end
    release_front("full0");
    checks++; if (fill_count !== 3'd3 || rx_empty !== 1'b0) begin
      errors++; $display("FAIL full_rel got=fill%0d empty%0d want=fill3 empty0", fill_count, rx_empty); end
    tick;
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL full_reopen got=%0d want=1", rx_empty); end
    while (sb.size() > 0) release_front("full_drain");
    tick;
    checks++; if (host_valid !== 1'b0 || host_frame_len !== 12'd0) begin
      errors++; $display("FAIL full_drained got=v%0d len=%h want=v0 len=0", host_valid, host_frame_len); end
  endtask

  task automatic test_back_to_back;
    desc_t d;
    do_reset;
    send_frame(12'd300, 64'hA0); wait_ready("b2b");
    send_frame(12'd301, 64'hA1); wait_ready("b2b");
    for (int k = 0; k < 2; k++) begin
      tick;
      d = sb.pop_front();
      checks++; if (host_frame_len !== d.len || host_timestamp !== d.ts) begin
        errors++; $display("FAIL b2b_desc%0d got=%h/%h want=%h/%h", k, host_frame_len, host_timestamp, d.len, d.ts); end
      d.len = 12'(310 + k); d.ts = 64'(64'hB0 + k);
      sb.push_back(d);
      rx_frame_len = d.len; rx_timestamp = d.ts;
      rx_complete = 1'b1; host_release = 1'b1;
      tick;
      rx_complete = 1'b0; host_release = 1'b0;
      checks++; if (fill_count !== 3'd2) begin errors++; $display("FAIL b2b_fill%0d got=%0d want=2", k, fill_count); end
      checks++; if (rx_wr_slot !== 2'((3 + k) % 4) || host_rd_slot !== 2'(1 + k)) begin
        errors++; $display("FAIL b2b_ptr%0d got=wr%0d rd%0d want=wr%0d rd%0d",
                           k, rx_wr_slot, host_rd_slot, (3 + k) % 4, 1 + k); end
      wait_ready("b2b");
    end
    while (sb.size() > 0) release_front("b2b_drain");
  endtask

  task automatic test_irq_threshold;
    do_reset;
    irq_enable = 1'b1; irq_threshold = 3'd3; irq_timeout = 16'd0;
    send_frame(12'd400, 64'hC0); wait_ready("thr");
    send_frame(12'd401, 64'hC1); wait_ready("thr");
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_two_frames got=%0d want=0", irq); end
    send_frame(12'd402, 64'hC2);
    checks++; if (fill_count !== 3'd3 || irq !== 1'b0) begin
      errors++; $display("FAIL thr_third_edge got=fill%0d irq%0d want=fill3 irq0", fill_count, irq); end
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL thr_assert got=%0d want=1", irq); end
    irq_ack = 1'b1; tick; irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_ack got=%0d want=0", irq); end
    tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_rewait got=%0d want=0", irq); end
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL thr_reassert got=%0d want=1", irq); end
    irq_enable = 1'b0; tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL thr_enable_low got=%0d want=1", irq); end
    irq_ack = 1'b1; tick; irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_final_ack got=%0d want=0", irq); end
    while (sb.size() > 0) release_front("thr_drain");
  endtask

  task automatic test_irq_timeout;
    do_reset;
    irq_enable = 1'b1; irq_threshold = 3'd4; irq_timeout = 16'd10;
    send_frame(12'd500, 64'hD0);
    // WAIT is entered on the edge after the accept; irq rises 10 edges later.
    for (int i = 1; i <= 11; i++) begin
      tick;
      if (i == 10) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmo_early got=%0d want=0", irq); end
      end
      if (i == 11) begin
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmo_rise got=%0d want=1", irq); end
      end
    end
    irq_enable = 1'b0; irq_ack = 1'b1; tick; irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmo_ack got=%0d want=0", irq); end
    release_front("tmo");
    tick;
    host_release = 1'b1; tick; host_release = 1'b0;
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL tmo_bad_rel_err got=%0d want=1", err_count); end
    checks++; if (host_rd_slot !== 2'd1 || rx_wr_slot !== 2'd1 || fill_count !== 3'd0) begin
      errors++; $display("FAIL tmo_bad_rel_ptr got=rd%0d wr%0d fill%0d want=rd1 wr1 fill0",
                         host_rd_slot, rx_wr_slot, fill_count); end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_single;
    test_full;
    test_back_to_back;
    test_irq_threshold;
    test_irq_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
